// File: rtl/ofs_plat_avalon_mem_almfull_cmd_buf.sv
// ofs_plat_avalon_mem_almfull_cmd_buf
//
// Command buffer placed directly upstream of a clock-crossing shim that runs
// in almost-full mode. The source side is standard Avalon-MM, where
// waitrequest is honoured combinationally. The sink side only issues a command
// in a cycle where the sink's registered almost-full waitrequest is low. The
// sink's post-waitrequest allowance is never used, so a command is never
// stranded in the shim.
//
// Each accepted source cycle occupies one FIFO entry, so a write burst takes
// one entry per beat. Commands leave in acceptance order.
//
// Optional statistics are enabled by defining the macro
// OFS_PLAT_AVALON_MEM_ALMFULL_CMD_BUF_STATS_EN. Without it, both stat outputs
// are tied to zero and no stat registers exist.

module ofs_plat_avalon_mem_almfull_cmd_buf #(
    parameter int ADDR_WIDTH      = 32,
    parameter int DATA_WIDTH      = 512,
    parameter int BURST_CNT_WIDTH = 7,
    parameter int USER_WIDTH      = 1,
    parameter int DEPTH           = 4
) (
    input  logic                          clk,
    input  logic                          reset,

    input  logic                          src_read,
    input  logic                          src_write,
    input  logic [ADDR_WIDTH-1:0]         src_address,
    input  logic [BURST_CNT_WIDTH-1:0]    src_burstcount,
    input  logic [DATA_WIDTH-1:0]         src_writedata,
    input  logic [DATA_WIDTH/8-1:0]       src_byteenable,
    input  logic [USER_WIDTH-1:0]         src_user,
    output logic                          src_waitrequest,

    output logic                          snk_read,
    output logic                          snk_write,
    output logic [ADDR_WIDTH-1:0]         snk_address,
    output logic [BURST_CNT_WIDTH-1:0]    snk_burstcount,
    output logic [DATA_WIDTH-1:0]         snk_writedata,
    output logic [DATA_WIDTH/8-1:0]       snk_byteenable,
    output logic [USER_WIDTH-1:0]         snk_user,
    input  logic                          snk_waitrequest,

    output logic [31:0]                   stat_stall_cycles,
    output logic [$clog2(DEPTH):0]        stat_peak_occupancy
);

    localparam int PW  = $clog2(DEPTH);
    localparam int CW  = PW + 1;
    localparam int BEW = DATA_WIDTH / 8;
    localparam int EW  = 2 + ADDR_WIDTH + BURST_CNT_WIDTH + DATA_WIDTH + BEW + USER_WIDTH;

    localparam logic [CW-1:0] FULL_CNT  = CW'(DEPTH);
    localparam logic [CW-1:0] ZERO_CNT  = {CW{1'b0}};
    localparam logic [CW-1:0] ONE_CNT   = {{(CW-1){1'b0}}, 1'b1};
    localparam logic [PW-1:0] ONE_PTR   = {{(PW-1){1'b0}}, 1'b1};

    // Entry storage. Data is not reset; only the control state is reset.
    logic [EW-1:0]   mem_q [DEPTH];

    logic [PW-1:0]   wr_ptr_q, wr_ptr_d;
    logic [PW-1:0]   rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]   count_q,  count_d;

    logic            enq_s;
    logic            deq_s;
    logic            head_valid_s;
    logic [EW-1:0]   enq_entry_s;
    logic [EW-1:0]   head_entry_s;
    logic            head_read_s;
    logic            head_write_s;

    // Back-pressure to the source depends only on the registered occupancy.
    assign src_waitrequest = (count_q == FULL_CNT);

    // Enqueue/dequeue decisions and next-state control for pointers and count.
    always_comb begin
        enq_s        = (src_read | src_write) & ~src_waitrequest;
        head_valid_s = (count_q != ZERO_CNT);
        deq_s        = head_valid_s & ~snk_waitrequest;
        enq_entry_s  = {src_read, src_write, src_address, src_burstcount,
                        src_writedata, src_byteenable, src_user};

        // DEPTH is a power of 2, so pointers wrap naturally modulo DEPTH.
        if (enq_s) begin
            wr_ptr_d = wr_ptr_q + ONE_PTR;
        end else begin
            wr_ptr_d = wr_ptr_q;
        end

        if (deq_s) begin
            rd_ptr_d = rd_ptr_q + ONE_PTR;
        end else begin
            rd_ptr_d = rd_ptr_q;
        end

        case ({enq_s, deq_s})
            2'b10:   count_d = count_q + ONE_CNT;
            2'b01:   count_d = count_q - ONE_CNT;
            default: count_d = count_q;
        endcase
    end

    // Control state register, cleared asynchronously so buffered entries are discarded.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wr_ptr_q <= {PW{1'b0}};
            rd_ptr_q <= {PW{1'b0}};
            count_q  <= ZERO_CNT;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // Entry storage write on each accepted source cycle.
    always_ff @(posedge clk) begin
        if (enq_s) begin
            mem_q[wr_ptr_q] <= enq_entry_s;
        end
    end

    // Present the head entry. Strobes are only asserted in a cycle where the
    // head retires, so the sink's waitrequest allowance is never consumed.
    always_comb begin
        head_entry_s = mem_q[rd_ptr_q];
        {head_read_s, head_write_s, snk_address, snk_burstcount,
         snk_writedata, snk_byteenable, snk_user} = head_entry_s;
        snk_read  = deq_s & head_read_s;
        snk_write = deq_s & head_write_s;
    end

`ifdef OFS_PLAT_AVALON_MEM_ALMFULL_CMD_BUF_STATS_EN
    logic [31:0]   stall_q, stall_d;
    logic [CW-1:0] peak_q,  peak_d;

    // Stall counter saturates; peak tracks the occupancy after this edge so it
    // always includes the count currently visible.
    always_comb begin
        if (head_valid_s && snk_waitrequest && (stall_q != 32'hFFFF_FFFF)) begin
            stall_d = stall_q + 32'd1;
        end else begin
            stall_d = stall_q;
        end

        if (count_d > peak_q) begin
            peak_d = count_d;
        end else begin
            peak_d = peak_q;
        end
    end

    // Statistics registers, cleared with the control state.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            stall_q <= 32'd0;
            peak_q  <= ZERO_CNT;
        end else begin
            stall_q <= stall_d;
            peak_q  <= peak_d;
        end
    end

    assign stat_stall_cycles   = stall_q;
    assign stat_peak_occupancy = peak_q;
`else
    assign stat_stall_cycles   = 32'd0;
    assign stat_peak_occupancy = {CW{1'b0}};
`endif

endmodule

// File: tb/tb_ofs_plat_avalon_mem_almfull_cmd_buf.sv
// Testbench for ofs_plat_avalon_mem_almfull_cmd_buf.
// A driver issues directed and random Avalon commands and pushes each accepted
// command onto a scoreboard queue. A monitor on the falling edge checks the
// sink strobes, fields, back-pressure and statistics against that queue.

module tb_ofs_plat_avalon_mem_almfull_cmd_buf;

    localparam int AW    = 32;
    localparam int DW    = 64;
    localparam int BW    = 7;
    localparam int UW    = 2;
    localparam int DEPTH = 4;
    localparam int CW    = $clog2(DEPTH) + 1;
    localparam int BEW   = DW / 8;

    typedef struct packed {
        logic           rd;
        logic           wr;
        logic [AW-1:0]  addr;
        logic [BW-1:0]  bc;
        logic [DW-1:0]  data;
        logic [BEW-1:0] be;
        logic [UW-1:0]  user;
    } cmd_t;

    logic           clk;
    logic           reset;
    logic           src_read, src_write;
    logic [AW-1:0]  src_address;
    logic [BW-1:0]  src_burstcount;
    logic [DW-1:0]  src_writedata;
    logic [BEW-1:0] src_byteenable;
    logic [UW-1:0]  src_user;
    logic           src_waitrequest;
    logic           snk_read, snk_write;
    logic [AW-1:0]  snk_address;
    logic [BW-1:0]  snk_burstcount;
    logic [DW-1:0]  snk_writedata;
    logic [BEW-1:0] snk_byteenable;
    logic [UW-1:0]  snk_user;
    logic           snk_waitrequest;
    logic [31:0]    stat_stall_cycles;
    logic [CW-1:0]  stat_peak_occupancy;

    ofs_plat_avalon_mem_almfull_cmd_buf #(
        .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .BURST_CNT_WIDTH(BW),
        .USER_WIDTH(UW), .DEPTH(DEPTH)
    ) dut (
        .clk(clk), .reset(reset),
        .src_read(src_read), .src_write(src_write), .src_address(src_address),
        .src_burstcount(src_burstcount), .src_writedata(src_writedata),
        .src_byteenable(src_byteenable), .src_user(src_user),
        .src_waitrequest(src_waitrequest),
        .snk_read(snk_read), .snk_write(snk_write), .snk_address(snk_address),
        .snk_burstcount(snk_burstcount), .snk_writedata(snk_writedata),
        .snk_byteenable(snk_byteenable), .snk_user(snk_user),
        .snk_waitrequest(snk_waitrequest),
        .stat_stall_cycles(stat_stall_cycles),
        .stat_peak_occupancy(stat_peak_occupancy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    cmd_t sb[$];            // accepted, not yet issued (reference FIFO contents)
    cmd_t cur;              // command currently presented by the driver
    bit   accept_ok;        // reference says the presented command is accepted at the coming edge
    bit   taken;
    int   wr_mode;          // 0 random, 1 always high, 2 always low, 3 toggle
    int   wr_pct;
    bit   wr_tgl;
    int   checks = 0;
    int   errors = 0;
    longint stall_m;
    int   peak_m;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h expected=%0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic cmd_t idle_cmd();
        cmd_t c;
        c = '0;
        return c;
    endfunction

    function automatic cmd_t rand_cmd(input bit is_rd);
        cmd_t c;
        c.rd   = is_rd;
        c.wr   = ~is_rd;
        c.addr = $urandom;
        c.bc   = BW'($urandom_range(127, 1));
        c.data = {$urandom, $urandom};
        c.be   = BEW'($urandom);
        c.user = UW'($urandom);
        return c;
    endfunction

    // Drive one cycle: present cur and snk_waitrequest, then record acceptance.
    task automatic run_cycle();
        src_read       = cur.rd;
        src_write      = cur.wr;
        src_address    = cur.addr;
        src_burstcount = cur.bc;
        src_writedata  = cur.data;
        src_byteenable = cur.be;
        src_user       = cur.user;
        case (wr_mode)
            1:       snk_waitrequest = 1'b1;
            2:       snk_waitrequest = 1'b0;
            3:       begin snk_waitrequest = wr_tgl; wr_tgl = ~wr_tgl; end
            default: snk_waitrequest = ($urandom_range(99) < wr_pct);
        endcase
        @(posedge clk);
        #1;
        taken = 1'b0;
        if ((cur.rd || cur.wr) && accept_ok) begin
            sb.push_back(cur);
            taken = 1'b1;
        end
    endtask

    task automatic send(input cmd_t c, input int max_cycles);
        int n;
        cur = c;
        n = 0;
        do begin
            run_cycle();
            n++;
        end while (!taken && n < max_cycles);
        if (!taken) begin
            errors++;
            checks++;
            $display("FAIL send_timeout actual=not_accepted expected=accepted at %0t", $time);
        end
    endtask

    task automatic idle(input int n);
        cur = idle_cmd();
        repeat (n) run_cycle();
    endtask

    // Asynchronous reset pulse while entries are buffered.
    task automatic pulse_reset();
        @(posedge clk);
        #2;
        snk_waitrequest = 1'b0;
        src_read  = 1'b0;
        src_write = 1'b0;
        cur = idle_cmd();
        reset = 1'b1;
        sb.delete();
        stall_m = 0;
        peak_m  = 0;
        accept_ok = 1'b0;
        #1;
        chk("reset_snk_strobes", {62'd0, snk_read, snk_write}, 64'd0);
        chk("reset_src_waitreq", {63'd0, src_waitrequest}, 64'd0);
        chk("reset_stall",       {32'd0, stat_stall_cycles}, 64'd0);
        chk("reset_peak",        {{(64-CW){1'b0}}, stat_peak_occupancy}, 64'd0);
        @(posedge clk);
        #2;
        reset = 1'b0;
    endtask

    // Monitor: compare DUT outputs against the reference queue every cycle.
    always @(negedge clk) begin : mon
        int   n;
        bit   exp_issue;
        cmd_t e;
        if (!reset) begin
            n = sb.size();
            exp_issue = (n > 0) && !snk_waitrequest;
            chk("src_waitrequest", {63'd0, src_waitrequest}, {63'd0, (n == DEPTH)});
            chk("snk_strobe", {63'd0, (snk_read | snk_write)}, {63'd0, exp_issue});
            if (snk_read || snk_write) begin
                if (n == 0) begin
                    errors++;
                    checks++;
                    $display("FAIL snk_unexpected actual=strobe expected=idle at %0t", $time);
                end else begin
                    e = sb.pop_front();
                    chk("snk_hdr", {47'd0, snk_read, snk_write, snk_burstcount, snk_byteenable},
                                   {47'd0, e.rd, e.wr, e.bc, e.be});
                    chk("snk_addr_user", {30'd0, snk_address, snk_user}, {30'd0, e.addr, e.user});
                    chk("snk_data", snk_writedata, e.data);
                end
            end
`ifdef OFS_PLAT_AVALON_MEM_ALMFULL_CMD_BUF_STATS_EN
            if (n > peak_m) peak_m = n;
            chk("stat_stall", {32'd0, stat_stall_cycles}, 64'(stall_m));
            chk("stat_peak",  {{(64-CW){1'b0}}, stat_peak_occupancy}, 64'(peak_m));
            if (n > 0 && snk_waitrequest) stall_m++;
`else
            chk("stat_stall_off", {32'd0, stat_stall_cycles}, 64'd0);
            chk("stat_peak_off",  {{(64-CW){1'b0}}, stat_peak_occupancy}, 64'd0);
`endif
            accept_ok = (n < DEPTH);
        end
    end

    initial begin
        cmd_t c;
        reset = 1'b1;
        src_read = 1'b0; src_write = 1'b0;
        src_address = '0; src_burstcount = '0; src_writedata = '0;
        src_byteenable = '0; src_user = '0;
        snk_waitrequest = 1'b0;
        cur = idle_cmd();
        accept_ok = 1'b0;
        wr_mode = 2; wr_pct = 50; wr_tgl = 1'b1;
        stall_m = 0; peak_m = 0;
        #1;
        chk("por_snk_strobes", {62'd0, snk_read, snk_write}, 64'd0);
        chk("por_src_waitreq", {63'd0, src_waitrequest}, 64'd0);
        repeat (2) @(posedge clk);
        #2;
        reset = 1'b0;
        @(posedge clk);
        #1;

        // Single read at 0x40, drained in the following cycle.
        c = rand_cmd(1'b1);
        c.addr = 32'h0000_0040;
        c.bc   = 7'd1;
        send(c, 4);
        idle(3);

        // Fill with the sink stalled; a fifth beat is held until a drain.
        wr_mode = 1;
        for (int i = 0; i < 4; i++) send(rand_cmd(1'b0), 4);
        cur = rand_cmd(1'b0);
        for (int i = 0; i < 3; i++) begin
            run_cycle();
            chk("fill_fifth_held", {63'd0, taken}, 64'd0);
        end
        wr_mode = 2;
        send(cur, 4);
        idle(8);

        // Streaming with the sink open: pointers wrap several times.
        for (int i = 0; i < 13; i++) send(rand_cmd(1'b0), 4);
        idle(4);

        // Alternating sink back-pressure: three write beats then a read.
        wr_mode = 3;
        for (int i = 0; i < 3; i++) send(rand_cmd(1'b0), 4);
        send(rand_cmd(1'b1), 4);
        idle(10);

        // Reset with three entries buffered; the next read is issued first.
        wr_mode = 1;
        for (int i = 0; i < 3; i++) send(rand_cmd(1'b0), 4);
        pulse_reset();
        wr_mode = 2;
        send(rand_cmd(1'b1), 4);
        idle(3);

        // Ten stall cycles with one entry held.
        pulse_reset();
        wr_mode = 1;
        send(rand_cmd(1'b0), 4);
        idle(10);
        wr_mode = 2;
        idle(3);

        // Randomized traffic and back-pressure.
        wr_mode = 0;
        for (int i = 0; i < 1500; i++) begin
            if (i % 150 == 0) wr_pct = $urandom_range(90);
            if ($urandom_range(99) < 70) send(rand_cmd($urandom_range(1) == 1), 200);
            else idle(1);
        end

        wr_mode = 2;
        idle(10);
        chk("drain_empty", 64'(sb.size()), 64'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/ofs_plat_avalon_mem_almfull_cmd_buf.md
OFS_PLAT_AVALON_MEM_ALMFULL_CMD_BUF -- requirements
Module: ofs_plat_avalon_mem_almfull_cmd_buf

Single-clock command buffer placed directly upstream of the clock-crossing shim when the shim runs in almost-full mode. It accepts standard Avalon-MM commands from the source, where waitrequest is honoured combinationally. It issues commands to the shim, whose waitrequest is a registered almost-full signal.

Interface
REQ-001 Parameter ADDR_WIDTH, default 32: address width.
REQ-002 Parameter DATA_WIDTH, default 512: data width; byteenable width is DATA_WIDTH/8.
REQ-003 Parameter BURST_CNT_WIDTH, default 7: burstcount width.
REQ-004 Parameter USER_WIDTH, default 1: user width.
REQ-005 Parameter DEPTH, default 4: FIFO entries; a power of 2, at least 2.
REQ-006 Ports, clock and reset first:
- clk  in  1  block clock.
- reset  in  1  asynchronous, active-high reset.
- src_read / src_write  in  1 each  source command strobes; never both high in one cycle.
- src_address  in  ADDR_WIDTH  address.
- src_burstcount  in  BURST_CNT_WIDTH  burst length.
- src_writedata  in  DATA_WIDTH  write data.
- src_byteenable  in  DATA_WIDTH/8  byte enables.
- src_user  in  USER_WIDTH  user bits.
- src_waitrequest  out  1  standard back-pressure.
- snk_read / snk_write  out  1 each  sink command strobes.
- snk_address, snk_burstcount, snk_writedata, snk_byteenable, snk_user  out  widths as src_*  sink command fields.
- snk_waitrequest  in  1  almost-full back-pressure from the sink.
- stat_stall_cycles  out  32  stall counter (REQ-024).
- stat_peak_occupancy  out  $clog2(DEPTH)+1  peak FIFO occupancy (REQ-024).

Function
REQ-007 A source command is accepted on a rising clk edge when (src_read or src_write) is high and src_waitrequest is low.
REQ-008 Each accepted cycle is one FIFO entry; write bursts therefore occupy one entry per beat.
REQ-009 An entry holds {read, write, address, burstcount, writedata, byteenable, user}.
REQ-010 src_waitrequest is combinational and equals (count == DEPTH).
REQ-011 count is a register of $clog2(DEPTH)+1 bits.
REQ-012 Sink issue condition: head valid and snk_waitrequest low, sampled at the same edge.
REQ-013 When the issue condition holds, the head entry is presented and retired in that cycle; the sink is never back-pressured by this block.
REQ-014 snk_read and snk_write are driven low whenever the issue condition is false; the sink tolerates up to its threshold of commands after waitrequest, and this block uses none of that allowance.
REQ-015 Minimum latency is one cycle: a command accepted at edge N appears on snk_* during cycle N+1 if snk_waitrequest is low.
REQ-016 Commands leave in strict acceptance order; reads and writes are never reordered.
REQ-017 Simultaneous enqueue and dequeue leaves count unchanged. This is legal at every count below DEPTH; at DEPTH, enqueue is blocked.
REQ-018 Empty: snk strobes are low regardless of snk_waitrequest.
REQ-019 Read and write pointers are $clog2(DEPTH) bits and wrap modulo DEPTH without a gap cycle.
REQ-020 The block does not inspect burstcount; it passes it unmodified.

Reset
REQ-021 Asserting reset asynchronously clears count, the pointers and all stat registers; snk_read = snk_write = 0 and src_waitrequest = 0 while count = 0.
REQ-022 Reset asserted mid-burst discards every buffered entry; no partial command is issued after reset deasserts.
REQ-023 FIFO data storage is not reset; only control state is reset.

Configuration
REQ-024 With macro OFS_PLAT_AVALON_MEM_ALMFULL_CMD_BUF_STATS_EN defined:
- stat_stall_cycles increments, saturating at 2^32-1, in every cycle with count > 0 and snk_waitrequest high.
- stat_peak_occupancy holds the maximum count since reset.
REQ-025 Without the macro, both stat outputs are constant 0 and no stat registers are synthesized.

Verification
REQ-026 Single read: src_read=1, address 0x40, burstcount 1 at edge 0, snk_waitrequest=0 -> snk_read=1 with address 0x40 in cycle 1, then the FIFO is empty.
REQ-027 Fill: DEPTH=4, snk_waitrequest=1, four write beats -> src_waitrequest=1 after the fourth edge; a fifth beat held on the source is not accepted until one entry drains.
REQ-028 Streaming: continuous writes with snk_waitrequest=0 -> one snk_write per cycle, data in order, count never exceeds 1, pointers wrap correctly after four entries.
REQ-029 Back-pressure toggle: snk_waitrequest alternating 1/0 with a 3-beat write (data A, B, C) then a read -> sink sees A, B, C, then the read; strobes are low on every waitrequest-high cycle.
REQ-030 Reset mid-operation: three entries buffered, reset pulsed for 1 cycle -> snk strobes are 0 immediately, count = 0, and the next accepted read is the first command issued.
REQ-031 With STATS_EN: 10 stall cycles with count > 0 -> stat_stall_cycles = 10 and stat_peak_occupancy = the maximum count reached; without STATS_EN both read 0.
